// File: rtl/motor_step_seq_pkg.sv
// Shared types and constants for the stepper phase sequencer.
// Holds the coil pattern table, FSM state encoding and position width.
// Also holds the per-step index delta helper used by the sequencer core.
package motor_step_pkg;

    localparam int POS_W = 16;

    // Coil drive {A+, B+, A-, B-} for phase index 0..7 (entry 0 is the LSB nibble).
    localparam logic [7:0][3:0] PHASE_PAT = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Signed index change for one step. In full-step mode an even index is a
    // single-coil position, so the first move lands on the next odd
    // (two-coil) index and later moves skip by two.
    function automatic logic signed [2:0] step_delta(
        input logic [2:0] idx,
        input logic       dir,
        input logic       half
    );
        logic signed [2:0] mag;
        mag = (half || !idx[0]) ? 3'sd1 : 3'sd2;
        return dir ? mag : -mag;
    endfunction

endpackage

// File: rtl/motor_step_seq_if.sv
// Control/status bundle between a step-rate source and the phase sequencer.
// master: drives STEP/DIR/HALF/ENABLE and observes BOBINAS/BUSY/POS.
// slave: the sequencer side; no handshake, ENABLE must be synchronous to CLK.
interface motor_step_seq_if;
    import motor_step_pkg::*;

    logic                    STEP;
    logic                    DIR;
    logic                    HALF;
    logic                    ENABLE;
    logic [3:0]              BOBINAS;
    logic                    BUSY;
    logic signed [POS_W-1:0] POS;

    modport master (
        output STEP, DIR, HALF, ENABLE,
        input  BOBINAS, BUSY, POS
    );

    modport slave (
        input  STEP, DIR, HALF, ENABLE,
        output BOBINAS, BUSY, POS
    );
endinterface

// File: rtl/motor_step_seq_sync.sv
// Synchronizer chain for STEP/DIR/HALF plus rising-edge detect on STEP.
// Latency: step_pulse is high in the cycle after SYNC_STAGES edges have seen STEP=1.
// No backpressure: every synchronized rising edge yields one single-cycle pulse.
// Ports: clk, rst (sync, active-high), step/dir/half in; step_pulse, dir_s, half_s out.
module step_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic dir,
    input  logic half,
    output logic step_pulse,
    output logic dir_s,
    output logic half_s
);
    logic [SYNC_STAGES-1:0] step_sr;
    logic [SYNC_STAGES-1:0] dir_sr;
    logic [SYNC_STAGES-1:0] half_sr;
    logic                   step_last;

    // DIR and HALF ride the same depth of chain as STEP so the direction
    // and mode seen with a pulse are the ones present alongside that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_sr   <= '0;
            dir_sr    <= '0;
            half_sr   <= '0;
            step_last <= 1'b0;
        end else begin
            step_sr   <= {step_sr[SYNC_STAGES-2:0], step};
            dir_sr    <= {dir_sr[SYNC_STAGES-2:0], dir};
            half_sr   <= {half_sr[SYNC_STAGES-2:0], half};
            step_last <= step_sr[SYNC_STAGES-1];
        end
    end

    assign step_pulse = step_sr[SYNC_STAGES-1] & ~step_last;
    assign dir_s      = dir_sr[SYNC_STAGES-1];
    assign half_s     = half_sr[SYNC_STAGES-1];
endmodule

// File: rtl/motor_step_seq.sv
// Stepper phase sequencer: full/half-step coil patterns with an all-off dead time per change.
// Latency: step accepted SYNC_STAGES edges after STEP is first sampled high; pattern follows DEAD_CYCLES later.
// No backpressure: steps arriving during dead time are accepted and restart the dead time.
// Ports: CLK, RST (sync, active-high), bus (slave: STEP/DIR/HALF/ENABLE in, BOBINAS/BUSY/POS out).
// Build option MOTOR_POS_EN: when defined, POS accumulates signed half-step moves; otherwise POS is 0.
module motor_step_seq
    import motor_step_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEAD_CYCLES = 50
) (
    input  logic CLK,
    input  logic RST,
    motor_step_seq_if.slave bus
);
    localparam int DC_W = $clog2(DEAD_CYCLES + 1);
    localparam logic [DC_W-1:0] DC_LOAD = DC_W'(DEAD_CYCLES);

    state_t            state;
    logic [2:0]        idx;
    logic [2:0]        idx_nxt;
    logic [DC_W-1:0]   dc;
    logic [3:0]        coils;
    logic              busy;
    logic signed [2:0] delta;
    logic              step_pulse;
    logic              dir_s;
    logic              half_s;

    step_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk        (CLK),
        .rst        (RST),
        .step       (bus.STEP),
        .dir        (bus.DIR),
        .half       (bus.HALF),
        .step_pulse (step_pulse),
        .dir_s      (dir_s),
        .half_s     (half_s)
    );

    always_comb begin
        delta   = step_delta(idx, dir_s, half_s);
        idx_nxt = idx + $unsigned(delta);
    end

    // ENABLE low overrides everything; IDX is kept so re-enabling restores
    // the same pattern after a fresh dead time.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            idx   <= 3'd0;
            dc    <= '0;
            coils <= 4'b0000;
            busy  <= 1'b0;
        end else if (!bus.ENABLE) begin
            state <= IDLE;
            coils <= 4'b0000;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= DEAD;
                    dc    <= DC_LOAD;
                    busy  <= 1'b1;
                    coils <= 4'b0000;
                end
                HOLD: begin
                    if (step_pulse) begin
                        idx   <= idx_nxt;
                        state <= DEAD;
                        dc    <= DC_LOAD;
                        busy  <= 1'b1;
                        coils <= 4'b0000;
                    end
                end
                DEAD: begin
                    // A new step here restarts the gap so the coils never
                    // jump straight between two energised patterns.
                    if (step_pulse) begin
                        idx <= idx_nxt;
                        dc  <= DC_LOAD;
                    end else if (dc == DC_W'(1)) begin
                        state <= HOLD;
                        busy  <= 1'b0;
                        coils <= PHASE_PAT[idx];
                    end else begin
                        dc <= dc - DC_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    coils <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BOBINAS = coils;
    assign bus.BUSY    = busy;

`ifdef MOTOR_POS_EN
    logic                    accept;
    logic signed [POS_W-1:0] pos;

    // Same acceptance condition as the IDX update in the FSM.
    assign accept = bus.ENABLE && step_pulse && (state == HOLD || state == DEAD);

    always_ff @(posedge CLK) begin
        if (RST) begin
            pos <= '0;
        end else if (accept) begin
            pos <= pos + {{(POS_W-3){delta[2]}}, delta};
        end
    end

    assign bus.POS = pos;
`else
    assign bus.POS = 16'sd0;
`endif

endmodule

// File: tb/tb_motor_step_seq.sv
module tb_motor_step_seq;

    localparam int SS = 2;
    localparam int DC = 6;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    motor_step_seq_if bus();

    motor_step_seq #(
        .SYNC_STAGES(SS),
        .DEAD_CYCLES(DC)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int                errors = 0;
    int                checks = 0;
    logic [2:0]        m_idx;
    logic signed [15:0] m_pos;
    logic [19:0]       exp_q[$];
    logic [3:0]        prev_coils;

    function automatic logic [3:0] pat(input logic [2:0] i);
        case (i)
            3'd0: return 4'b1000;
            3'd1: return 4'b1100;
            3'd2: return 4'b0100;
            3'd3: return 4'b0110;
            3'd4: return 4'b0010;
            3'd5: return 4'b0011;
            3'd6: return 4'b0001;
            default: return 4'b1001;
        endcase
    endfunction

    function automatic logic [15:0] exp_pos();
`ifdef MOTOR_POS_EN
        return m_pos;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_step(input logic d, input logic h);
        int dl;
        if (h) dl = 1;
        else if (m_idx[0]) dl = 2;
        else dl = 1;
        if (!d) dl = -dl;
        m_idx = m_idx + 3'(dl);
        m_pos = m_pos + 16'(dl);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One cycle, sampled on the falling edge; also runs the coil monitor and
    // pops the scoreboard each time a pattern appears out of all-off.
    task automatic tick();
        logic [19:0] e;
        @(negedge CLK);
        if (!RST) begin
            check("no_direct_switch",
                  32'((prev_coils != 4'b0000 && bus.BOBINAS != 4'b0000 && bus.BOBINAS != prev_coils) ? 1 : 0), 32'd0);
            if (prev_coils == 4'b0000 && bus.BOBINAS != 4'b0000) begin
                check("sb_pending", 32'((exp_q.size() > 0) ? 1 : 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_pattern", 32'(bus.BOBINAS), 32'(e[19:16]));
                    check("sb_pos", 32'(bus.POS), 32'(e[15:0]));
                end
            end
        end
        prev_coils = bus.BOBINAS;
    endtask

    // Fully timed single step from HOLD.
    task automatic do_step(input logic d, input logic h);
        logic [3:0] old_pat;
        old_pat = pat(m_idx);
        @(posedge CLK);
        #1;
        bus.DIR  = d;
        bus.HALF = h;
        bus.STEP = 1'b1;
        model_step(d, h);
        exp_q.push_back({pat(m_idx), exp_pos()});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pre_accept_busy", 32'(bus.BUSY), 32'd0);
            check("pre_accept_coils", 32'(bus.BOBINAS), 32'(old_pat));
        end
        bus.STEP = 1'b0;
        for (int i = 0; i < DC; i++) begin
            tick();
            check("dead_busy", 32'(bus.BUSY), 32'd1);
            check("dead_coils", 32'(bus.BOBINAS), 32'd0);
            if (i == 0) check("accept_pos", 32'(bus.POS), 32'(exp_pos()));
        end
        tick();
        check("post_dead_busy", 32'(bus.BUSY), 32'd0);
        check("post_dead_coils", 32'(bus.BOBINAS), 32'(pat(m_idx)));
        repeat (4) tick();
    endtask

    initial begin
        int n;
        bus.STEP   = 1'b0;
        bus.DIR    = 1'b1;
        bus.HALF   = 1'b1;
        bus.ENABLE = 1'b0;
        m_idx      = 3'd0;
        m_pos      = 16'sd0;
        prev_coils = 4'b0000;

        // Reset state
        repeat (3) tick();
        check("rst_coils", 32'(bus.BOBINAS), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_pos", 32'(bus.POS), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (2) tick();
        check("idle_coils", 32'(bus.BOBINAS), 32'd0);
        check("idle_busy", 32'(bus.BUSY), 32'd0);

        // Enable: dead time, then pattern for IDX 0
        @(posedge CLK);
        #1;
        bus.ENABLE = 1'b1;
        exp_q.push_back({pat(m_idx), exp_pos()});
        tick();
        check("en_pre_busy", 32'(bus.BUSY), 32'd0);
        for (int i = 0; i < DC; i++) begin
            tick();
            check("en_dead_busy", 32'(bus.BUSY), 32'd1);
            check("en_dead_coils", 32'(bus.BOBINAS), 32'd0);
        end
        tick();
        check("en_hold_coils", 32'(bus.BOBINAS), 32'(4'b1000));
        check("en_hold_busy", 32'(bus.BUSY), 32'd0);
        check("en_hold_pos", 32'(bus.POS), 32'd0);
        repeat (3) tick();

        // Eight forward half-steps: full cycle back to IDX 0
        for (int k = 0; k < 8; k++) do_step(1'b1, 1'b1);
        check("half_fwd_pos", 32'(bus.POS), 32'(exp_pos()));
        check("half_fwd_pat", 32'(bus.BOBINAS), 32'(4'b1000));

        // Full-step reverse from IDX 0: 7 then 5
        do_step(1'b0, 1'b0);
        check("full_rev_pat1", 32'(bus.BOBINAS), 32'(4'b1001));
        do_step(1'b0, 1'b0);
        check("full_rev_pat2", 32'(bus.BOBINAS), 32'(4'b0011));
        check("full_rev_pos", 32'(bus.POS), 32'(exp_pos()));

        // Two rising edges two cycles apart: both accepted, dead time restarts
        tick();
        bus.DIR  = 1'b1;
        bus.HALF = 1'b1;
        bus.STEP = 1'b1;
        tick();
        bus.STEP = 1'b0;
        tick();
        bus.STEP = 1'b1;
        model_step(1'b1, 1'b1);
        model_step(1'b1, 1'b1);
        exp_q.push_back({pat(m_idx), exp_pos()});
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (n == 1) begin
                bus.STEP = 1'b0;
                check("dbl_busy", 32'(bus.BUSY), 32'd1);
            end
            if (bus.BOBINAS != 4'b0000) break;
        end
        check("dbl_gap_cycles", 32'(n), 32'(DC + 3));
        check("dbl_pos", 32'(bus.POS), 32'(exp_pos()));
        repeat (3) tick();

        // ENABLE dropped mid-dead-time
        bus.STEP = 1'b1;
        model_step(1'b1, 1'b1);
        n = 0;
        while (n < 50) begin
            tick();
            n++;
            if (n == 1) bus.STEP = 1'b0;
            if (bus.BUSY) break;
        end
        check("dis_accept_cycles", 32'(n), 32'd3);
        repeat (2) tick();
        check("dis_mid_dead", 32'(bus.BUSY), 32'd1);
        bus.ENABLE = 1'b0;
        tick();
        check("dis_coils", 32'(bus.BOBINAS), 32'd0);
        check("dis_busy", 32'(bus.BUSY), 32'd0);
        check("dis_pos", 32'(bus.POS), 32'(exp_pos()));
        repeat (3) tick();
        check("dis_hold_coils", 32'(bus.BOBINAS), 32'd0);
        bus.ENABLE = 1'b1;
        exp_q.push_back({pat(m_idx), exp_pos()});
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (bus.BOBINAS != 4'b0000) break;
        end
        check("reen_cycles", 32'(n), 32'(DC + 1));
        check("reen_pattern", 32'(bus.BOBINAS), 32'(pat(m_idx)));
        repeat (3) tick();

        // Reset with a step edge in flight: edge discarded, all state cleared
        bus.STEP = 1'b1;
        tick();
        RST      = 1'b1;
        bus.STEP = 1'b0;
        tick();
        check("rst2_coils", 32'(bus.BOBINAS), 32'd0);
        check("rst2_busy", 32'(bus.BUSY), 32'd0);
        check("rst2_pos", 32'(bus.POS), 32'd0);
        RST = 1'b0;
        m_idx = 3'd0;
        m_pos = 16'sd0;
        exp_q.delete();
        exp_q.push_back({pat(3'd0), 16'h0000});
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (bus.BOBINAS != 4'b0000) break;
        end
        check("rst2_cycles", 32'(n), 32'(DC + 1));
        check("rst2_pattern", 32'(bus.BOBINAS), 32'(4'b1000));
        repeat (3) tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
